// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - parametrised pipeline register chain with stall/flush, bubbles and forwarding lookup (optional PIPE_PERF_CNT_EN)
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_wreg,
    input  logic [AW-1:0]     in_wd,
    output logic              in_ready,
    input  logic [STAGES-1:0] stall,
    input  logic [STAGES-1:0] flush,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_wreg,
    output logic [AW-1:0]     out_wd,
    input  logic [AW-1:0]     fwd_raddr,
    output logic              fwd_hit,
    output logic [WIDTH-1:0]  fwd_data,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
);

    // Stage storage, index 0 is the stage nearest the input
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_wreg;
    logic [AW-1:0]     r_wd   [STAGES];
    logic [WIDTH-1:0]  r_data [STAGES];

    // Freeze chain and what each stage would take from upstream
    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_up_valid;
    logic [STAGES-1:0] w_up_wreg;
    logic [STAGES-1:0] w_up_bubble;
    logic [AW-1:0]     w_up_wd   [STAGES];
    logic [WIDTH-1:0]  w_up_data [STAGES];

    // Next-state values for every stage
    logic [STAGES-1:0] w_nxt_valid;
    logic [STAGES-1:0] w_nxt_wreg;
    logic [AW-1:0]     w_nxt_wd   [STAGES];
    logic [WIDTH-1:0]  w_nxt_data [STAGES];

    logic [STAGES-1:0] w_match;

    // A stage is frozen when it or any stage downstream of it stalls
    always_comb begin
        w_hold = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_hold[i] = |(stall >> i);
        end
    end

    assign in_ready = ~w_hold[0];

    // Upstream source per stage; stage 0 turns an invalid input into a clean bubble
    always_comb begin
        w_up_valid     = '0;
        w_up_wreg      = '0;
        w_up_bubble    = '0;
        w_up_valid[0]  = in_valid;
        w_up_wreg[0]   = in_wreg & in_valid;
        w_up_wd[0]     = in_valid ? in_wd : '0;
        w_up_data[0]   = in_valid ? in_data : '0;
        w_up_bubble[0] = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            w_up_valid[i]  = r_valid[i-1];
            w_up_wreg[i]   = r_wreg[i-1];
            w_up_wd[i]     = r_wd[i-1];
            w_up_data[i]   = r_data[i-1];
            w_up_bubble[i] = w_hold[i-1];
        end
    end

    // Per-stage priority: flush, hold, bubble behind a frozen upstream, advance
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            w_nxt_valid[i] = r_valid[i];
            w_nxt_wreg[i]  = r_wreg[i];
            w_nxt_wd[i]    = r_wd[i];
            w_nxt_data[i]  = r_data[i];
            if (flush[i] || (!w_hold[i] && w_up_bubble[i])) begin
                w_nxt_valid[i] = 1'b0;
                w_nxt_wreg[i]  = 1'b0;
                w_nxt_wd[i]    = '0;
                w_nxt_data[i]  = '0;
            end else if (!w_hold[i]) begin
                w_nxt_valid[i] = w_up_valid[i];
                w_nxt_wreg[i]  = w_up_wreg[i] & w_up_valid[i];
                w_nxt_wd[i]    = w_up_wd[i];
                w_nxt_data[i]  = w_up_data[i];
            end
        end
    end

    // Stage registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_wreg  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_wd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= w_nxt_valid;
            r_wreg  <= w_nxt_wreg;
            for (int i = 0; i < STAGES; i++) begin
                r_wd[i]   <= w_nxt_wd[i];
                r_data[i] <= w_nxt_data[i];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_wreg  = r_wreg[STAGES-1];
    assign out_wd    = r_wd[STAGES-1];
    assign out_data  = r_data[STAGES-1];

    // Stages that currently produce the queried register; register 0 never matches
    always_comb begin
        w_match = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_match[i] = r_valid[i] & r_wreg[i] & (r_wd[i] == fwd_raddr) & (fwd_raddr != '0);
        end
    end

    // Youngest match wins: scan oldest to youngest so the lowest index overwrites
    always_comb begin
        fwd_hit  = |w_match;
        fwd_data = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                fwd_data = r_data[i];
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_hold[0] && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!r_valid[STAGES-1] && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_bubble_cnt = r_bubble_cnt;
`else
    assign perf_stall_cnt  = 32'h0;
    assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - self-checking bench for pipe_stage_chain
module tb_pipe_stage_chain;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int AW     = 5;

    typedef struct packed {
        logic             v;
        logic             w;
        logic [AW-1:0]    wd;
        logic [WIDTH-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_wreg = 1'b0;
    logic [AW-1:0]     in_wd = '0;
    logic              in_ready;
    logic [STAGES-1:0] stall = '0;
    logic [STAGES-1:0] flush = '0;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_wreg;
    logic [AW-1:0]     out_wd;
    logic [AW-1:0]     fwd_raddr = '0;
    logic              fwd_hit;
    logic [WIDTH-1:0]  fwd_data;
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_bubble_cnt;

    int checks = 0;
    int errors = 0;

    ent_t             m [STAGES] = '{default: '0};
    logic [31:0]      m_stall_cnt = '0;
    logic [31:0]      m_bubble_cnt = '0;
    logic             e_hit;
    logic [WIDTH-1:0] e_fd;
    logic [WIDTH-1:0] q_out [$];

    pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_wreg(in_wreg), .in_wd(in_wd),
        .in_ready(in_ready), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_wreg(out_wreg), .out_wd(out_wd),
        .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Stage i is frozen if any stall request sits at i or beyond
    function automatic logic frozen(input int i, input logic [STAGES-1:0] st);
        return (st >> i) != 0;
    endfunction

    function automatic void fwd_model(output logic hit, output logic [WIDTH-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (fwd_raddr != 0) begin
            for (int i = 0; i < STAGES; i++) begin
                if (!hit && m[i].v && m[i].w && (m[i].wd == fwd_raddr)) begin
                    hit = 1'b1;
                    d   = m[i].d;
                end
            end
        end
    endfunction

    // Reference pipeline
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) m[i] <= '0;
            m_stall_cnt  <= '0;
            m_bubble_cnt <= '0;
        end else begin
            if (stall != 0 && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt <= m_stall_cnt + 1;
            if (!m[STAGES-1].v && m_bubble_cnt != 32'hFFFF_FFFF) m_bubble_cnt <= m_bubble_cnt + 1;
            for (int i = 0; i < STAGES; i++) begin
                if (flush[i])                 m[i] <= '0;
                else if (frozen(i, stall))    m[i] <= m[i];
                else if (i == 0)              m[i] <= in_valid ? {1'b1, in_wreg, in_wd, in_data} : '0;
                else if (frozen(i - 1, stall)) m[i] <= '0;
                else                          m[i] <= m[i-1];
            end
        end
    end

    // Every-cycle comparison against the reference
    always @(negedge clk) begin
        fwd_model(e_hit, e_fd);
        chk("out_valid", out_valid, m[STAGES-1].v);
        chk("out_data", out_data, m[STAGES-1].d);
        chk("out_wreg", out_wreg, m[STAGES-1].w);
        chk("out_wd", out_wd, m[STAGES-1].wd);
        chk("in_ready", in_ready, stall == 0);
        chk("fwd_hit", fwd_hit, e_hit);
        chk("fwd_data", fwd_data, e_fd);
`ifdef PIPE_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, m_stall_cnt);
        chk("perf_bubble", perf_bubble_cnt, m_bubble_cnt);
`else
        chk("perf_stall", perf_stall_cnt, 0);
        chk("perf_bubble", perf_bubble_cnt, 0);
`endif
        if (out_valid) q_out.push_back(out_data);
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic w, input logic [AW-1:0] wd,
                         input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl);
        in_valid = v;
        in_data  = d;
        in_wreg  = w;
        in_wd    = wd;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    // Three items into an empty pipe appear after edges 4, 5, 6
    task automatic run_s1(input string tag);
        drive(1'b1, 32'h11, 1'b1, 5'd3, '0, '0);
        chk({tag, "_e1_valid"}, out_valid, 0);
        drive(1'b1, 32'h22, 1'b1, 5'd3, '0, '0);
        chk({tag, "_e2_valid"}, out_valid, 0);
        drive(1'b1, 32'h33, 1'b1, 5'd3, '0, '0);
        chk({tag, "_e3_valid"}, out_valid, 0);
        idle();
        chk({tag, "_e4_valid"}, out_valid, 1);
        chk({tag, "_e4_data"}, out_data, 32'h11);
        chk({tag, "_e4_wreg"}, out_wreg, 1);
        idle();
        chk({tag, "_e5_data"}, out_data, 32'h22);
        idle();
        chk({tag, "_e6_data"}, out_data, 32'h33);
        idle();
        chk({tag, "_e7_valid"}, out_valid, 0);
    endtask

    initial begin
        int k;
        logic [STAGES-1:0] st;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_fwd_hit", fwd_hit, 0);
        chk("rst_bubble_cnt", perf_bubble_cnt, 0);

        // 1: basic latency
        run_s1("s1");

        // 2: stall at stage 2 for two cycles
        repeat (4) idle();
        q_out.delete();
        k = 1;
        for (int c = 0; c < 14; c++) begin
            st = (c == 3 || c == 4) ? 4'b0100 : 4'b0000;
            drive(k <= 6, (k <= 6) ? k : 0, 1'b0, '0, st, '0);
            if (st == 0 && k <= 6) k++;
            if (c == 3) begin
                chk("s2_in_ready", in_ready, 0);
                chk("s2_bubble_out", out_valid, 0);
            end
            if (c == 5) chk("s2_first_out", out_data, 32'h1);
        end
        chk("s2_count", q_out.size(), 6);
        for (int j = 0; j < q_out.size() && j < 6; j++) chk("s2_seq", q_out[j], j + 1);

        // 3: flush stages 0,1 while stage 1 stalls
        repeat (4) idle();
        drive(1'b1, 32'h21, 1'b0, '0, '0, '0);
        drive(1'b1, 32'h22, 1'b0, '0, '0, '0);
        drive(1'b1, 32'h23, 1'b0, '0, '0, '0);
        drive(1'b1, 32'h24, 1'b0, '0, '0, '0);
        drive(1'b1, 32'h55, 1'b0, '0, 4'b0010, 4'b0011);
        chk("s3_out_valid", out_valid, 1);
        chk("s3_out_data", out_data, 32'h22);
        for (int j = 0; j < 3; j++) begin
            idle();
            chk("s3_drained", out_valid, 0);
        end

        // 4: forwarding picks the youngest writer
        drive(1'b1, 32'hB, 1'b1, 5'd5, '0, '0);
        drive(1'b1, 32'hA, 1'b1, 5'd5, '0, '0);
        idle();
        fwd_raddr = 5'd5;
        #1;
        chk("s4_hit", fwd_hit, 1);
        chk("s4_data", fwd_data, 32'hA);
        fwd_raddr = 5'd0;
        #1;
        chk("s4_r0_hit", fwd_hit, 0);
        chk("s4_r0_data", fwd_data, 0);
        fwd_raddr = 5'd6;
        #1;
        chk("s4_miss", fwd_hit, 0);
        fwd_raddr = 5'd5;
        idle();
        chk("s4_later_data", fwd_data, 32'hA);

        // 5: asynchronous reset mid-stream
        repeat (4) idle();
        fwd_raddr = 5'd7;
        drive(1'b1, 32'h61, 1'b1, 5'd7, '0, '0);
        drive(1'b1, 32'h62, 1'b1, 5'd7, '0, '0);
        chk("s5_fwd_young", fwd_data, 32'h62);
        drive(1'b1, 32'h63, 1'b1, 5'd7, '0, '0);
        drive(1'b1, 32'h64, 1'b1, 5'd7, '0, '0);
        chk("s5_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("s5_rst_valid", out_valid, 0);
        chk("s5_rst_wreg", out_wreg, 0);
        chk("s5_rst_hit", fwd_hit, 0);
        rst = 1'b0;
        run_s1("s5");

        // 6: performance counters from a fresh reset
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) drive(1'b0, '0, 1'b0, '0, 4'b0001, '0);
`ifdef PIPE_PERF_CNT_EN
        chk("s6_stall_cnt", perf_stall_cnt, 3);
        chk("s6_bubble_cnt", perf_bubble_cnt, 3);
`else
        chk("s6_stall_cnt", perf_stall_cnt, 0);
        chk("s6_bubble_cnt", perf_bubble_cnt, 0);
`endif
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
